// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and serial line constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a. The receive path imports the same constants.
package uart_pkg;

  // Transmit FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Parity selection as carried on par_typ.
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  // Serial line levels.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity bit register for the UART transmitter, loaded on frame accept.
// Latency: parity valid one edge after load (in time for the START cycle).
// Backpressure: none; load is only pulsed by the top-level FSM when idle.
//
// Ports:
//   clk, rst      bit clock, async active-low reset
//   load          accept strobe from the FSM
//   data, par_typ payload and parity type sampled on load
//   parity        registered parity bit for the frame in flight
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  // Even parity: bit equals XOR of the data so the total count of 1s is even.
  // Odd parity inverts it.
  logic par_bit;
  assign par_bit = (par_typ == PAR_ODD) ? ~(^data) : (^data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= par_bit;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte in, one serial frame out (start, data LSB first, optional parity, stop).
// Latency: start bit appears on tx_out right after the accepting edge; one clk per bit.
// Backpressure: busy is high for the whole frame; data_valid is ignored unless idle (no queuing).
//
// Ports:
//   clk         TX bit clock (one cycle per bit)
//   rst         async active-low reset, aborts any frame in flight
//   p_data      parallel payload, sampled on the accept edge
//   data_valid  send request, honoured only in IDLE
//   par_en      append a parity bit, sampled on the accept edge
//   par_typ     0 = even, 1 = odd parity, sampled on the accept edge
//   tx_out      registered serial line output, idles high
//   busy        registered, high from start bit through stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_bit;
  logic                  accept;
  logic                  tx_d;
  logic                  busy_d;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .data   (p_data),
    .par_typ(par_typ),
    .parity (par_bit)
  );

  // Next-state logic also computes the next line level so tx_out/busy can be
  // registered and still show the start bit right after the accept edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = LINE_IDLE;
    busy_d  = 1'b1;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (data_valid) begin
          accept  = 1'b1;
          state_d = START;
          tx_d    = START_BIT;
          busy_d  = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          // Counter holds at the last index; it never wraps inside DATA.
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit;
          end else begin
            state_d = STOP;
            tx_d    = STOP_BIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          tx_d  = data_q[cnt_d];
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = STOP_BIT;
      end
      STOP: begin
        // data_valid is not looked at here, which guarantees one idle bit
        // between back-to-back frames.
        state_d = IDLE;
        tx_d    = LINE_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      tx_out   <= LINE_IDLE;
      busy     <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tx_out <= tx_d;
      busy   <= busy_d;
      if (accept) begin
        data_q   <= p_data;
        par_en_q <= par_en;
      end
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter. It is the transmit-side counterpart of the UART receive path in the UART block.
- Accepts a parallel byte with a one-cycle valid strobe, then serializes one frame: start bit, data LSB first, optional parity, stop bit.
- Runs in the TX clock domain at one clk cycle per bit. The baud-rate clock is generated upstream by the clock divider.
- Output tx_out drives the serial line directly. busy back-pressures the upstream FIFO/controller.

Parameters:
- DATA_WIDTH, 8, number of payload bits per frame.

Ports:
- clk  input  1  TX bit clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- p_data  input  DATA_WIDTH  parallel payload; sampled only on the accept edge.
- data_valid  input  1  request to send p_data; honoured only while idle.
- par_en  input  1  1 = append parity bit; sampled on the accept edge.
- par_typ  input  1  0 = even parity, 1 = odd parity; sampled on the accept edge.
- tx_out  output  1  serial line; idle level is 1.
- busy  output  1  high from the first cycle of the start bit through the last cycle of the stop bit.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx_out=1, busy=0, data/parity registers and bit counter cleared.
- tx_out and busy are registered outputs; there is no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept: in IDLE, a rising edge with data_valid=1 latches p_data, par_en and par_typ, and moves the FSM to START. Immediately after that edge tx_out=0 and busy=1 (zero-cycle latency from accept to start bit).
- START: lasts 1 cycle, then DATA with bit counter=0.
- DATA: tx_out = latched_data[counter], LSB first. The counter increments each cycle. After the DATA_WIDTH-th bit (counter = DATA_WIDTH-1), go to PARITY if the latched par_en=1, else to STOP.
- PARITY: lasts 1 cycle; tx_out = XOR-reduce(latched_data) XOR latched par_typ.
  - Even parity: total count of 1s over data+parity is even.
  - Odd parity: total count of 1s over data+parity is odd.
- STOP: lasts 1 cycle with tx_out=1. The next edge returns to IDLE with busy=0 and tx_out=1.
- Frame length is 1+DATA_WIDTH+1 = 10 cycles without parity, and 11 cycles with parity. busy is high for exactly that many cycles.
- data_valid in any state other than IDLE is ignored; no queuing.
  - This includes the STOP cycle, so back-to-back frames have at least one idle cycle (tx_out=1) between the stop bit and the next start bit.
- p_data, par_en and par_typ changing mid-frame have no effect on the frame in flight.
- Reset asserted mid-frame: the frame is aborted immediately and outputs return to their reset values. No partial frame resumes after reset release.
- The bit counter is $clog2(DATA_WIDTH) bits wide and saturates at no value other than DATA_WIDTH-1. The counter never wraps inside DATA.

Decomposition:
- Shared package uart_pkg:
  - FSM state typedef/localparams: IDLE, START, DATA, PARITY, STOP.
  - Constants: PAR_EVEN=0, PAR_ODD=1, LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
  - The receive side reuses the same constants.
- One sub-module, uart_tx_parity_calc:
  - Registers the parity bit from the data and par_typ latched on accept.
  - The top level keeps the FSM, counter and output mux.

Test Plan:
- Reset, then idle 5 cycles -> tx_out=1 and busy=0 throughout.
- p_data=0xA5, par_en=0 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1 over 10 cycles; busy high for exactly 10 cycles.
- p_data=0xA5, par_en=1, par_typ=0 -> parity bit 0, 11-cycle frame. Same data with par_typ=1 -> parity bit 1.
- p_data=0x01, par_en=1, par_typ=1 -> data bits 1,0,0,0,0,0,0,0, parity 0, stop 1.
- Pulse data_valid with p_data=0xFF during the DATA state of a 0x00 frame -> the current frame completes as all-zero data; no second frame is sent.
- data_valid held high with 0x3C, then rst=0 pulsed at cycle 4 of the frame -> tx_out=1 and busy=0 at once. After release, a new full frame starts on the first edge with data_valid=1.
